reorder_buffer: RTL
===================

REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 The block SHALL have parameter SIZE, default 8, meaning the number of entries; SIZE is a power of two between 2 and 32.
REQ-002 The block SHALL have parameter WB_COUNT, default 1, meaning the number of writeback ports.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 IN_allocValid  in  1  request to allocate one entry this cycle.
REQ-007 IN_allocTagDst  in  6  physical destination tag of the allocating uop.
REQ-008 IN_allocNmDst  in  5  architectural destination register of the allocating uop.
REQ-009 OUT_allocSqN  out  6  sqN given to an accepted allocation; it equals the current tail, combinational.
REQ-010 OUT_full  out  1  high when the entry count equals SIZE, combinational.
REQ-011 IN_wbValid[WB_COUNT]  in  1 each  writeback strobe from the reservation-station issue path.
REQ-012 IN_wbSqN[WB_COUNT]  in  6 each  sqN of the completing uop.
REQ-013 IN_wbResult[WB_COUNT]  in  32 each  result value.
REQ-014 IN_invalidate  in  1  flush request.
REQ-015 IN_invalidateSqN  in  6  flush point; entries strictly younger than this sqN are discarded.
REQ-016 OUT_commitValid  out  1  registered; high for one cycle for each retired entry.
REQ-017 OUT_commitTagDst, OUT_commitNmDst, OUT_commitResult  out  6/5/32  registered fields of the retired entry.

Function
REQ-018 The block SHALL keep 6-bit head and tail sqN counters; count = tail - head modulo 64; an entry's index = sqN mod SIZE.
REQ-019 Age SHALL be compared as $signed(a - b) in 6 bits.
REQ-020 An allocation SHALL be accepted when IN_allocValid=1, OUT_full=0 and IN_invalidate=0.
  - Accepted: write {valid=1, done=0, tagDst, nmDst} at index(tail); tail increments by 1 and wraps at 64.
  - OUT_full SHALL use the count before any same-cycle commit, so no allocation is accepted into a slot that frees in the same cycle.
REQ-021 A writeback SHALL set done=1 and store the result for an entry only if:
  - the entry is valid;
  - its sqN is in [head, tail);
  - it is not flushed this cycle.
  Out-of-window writebacks SHALL be ignored.
REQ-022 When several writeback ports hit the same entry in one cycle, the highest port index SHALL win.
REQ-023 Commit: when count>0 and the head entry has done=1, the next edge SHALL register the head fields on OUT_commit*, set OUT_commitValid=1, clear the entry's valid bit and increment head. At most one commit per cycle.
REQ-024 A writeback to the head entry SHALL become visible to commit the following cycle, giving a minimum writeback-to-commit latency of 2 edges.
REQ-025 When no commit occurs, OUT_commitValid SHALL be 0 and the OUT_commit data fields SHALL hold their last values.
REQ-026 Invalidate:
  - Every entry with $signed(sqN - IN_invalidateSqN) > 0 SHALL be cleared.
  - tail SHALL become IN_invalidateSqN+1.
  - Allocation SHALL be blocked for that cycle.
  - A commit of the head SHALL still proceed if head is not younger than IN_invalidateSqN.
REQ-027 IN_invalidateSqN SHALL lie in [head-1, tail-1]; head-1 empties the buffer. Other values are illegal and the resulting behaviour is undefined.
REQ-028 The empty buffer (head==tail) SHALL never commit; a full buffer SHALL continue to commit and accept writebacks.

Reset
REQ-029 While rst_n=0, head, tail, all valid and done bits, OUT_commitValid, OUT_commitTagDst, OUT_commitNmDst and OUT_commitResult SHALL be 0.
REQ-030 During and after reset, OUT_full SHALL be 0 and OUT_allocSqN SHALL be 0.
REQ-031 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Verification
REQ-032 In-order retire:
  - Stimulus: allocate sqN 0,1,2; write back 2, then 0, then 1.
  - Required: commits occur in order 0,1,2; commit 0 follows its writeback by 2 edges.
REQ-033 Full boundary:
  - Stimulus: SIZE=8, allocate 8 entries, assert alloc while head is done.
  - Required: OUT_full=1; the alloc is rejected that cycle; the commit happens; OUT_full=0 the next cycle.
REQ-034 Wrap:
  - Stimulus: stream 70 alloc/writeback pairs.
  - Required: sqN wraps 63->0; commits are continuous and in order; result values match.
REQ-035 Flush:
  - Stimulus: allocate 0..5; write back 4; invalidate with sqN=2.
  - Required: tail=3; the writeback of 4 is lost; the next alloc gets sqN 3; only 0..2 commit.
REQ-036 Stray writeback:
  - Stimulus: writeback with sqN=7 while the window is [0,3).
  - Required: no state change.
REQ-037 Async reset:
  - Stimulus: drop rst_n between edges with 4 entries present.
  - Required: outputs are 0 immediately; the next alloc gets sqN 0.

Source files
------------

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates entries in program order, collects out-of-order
// writebacks, retires one completed head entry per cycle and supports flushes.
module reorder_buffer #(
    parameter int SIZE     = 8,
    parameter int WB_COUNT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        IN_allocValid,
    input  logic [5:0]  IN_allocTagDst,
    input  logic [4:0]  IN_allocNmDst,
    output logic [5:0]  OUT_allocSqN,
    output logic        OUT_full,
    input  logic        IN_wbValid  [WB_COUNT],
    input  logic [5:0]  IN_wbSqN    [WB_COUNT],
    input  logic [31:0] IN_wbResult [WB_COUNT],
    input  logic        IN_invalidate,
    input  logic [5:0]  IN_invalidateSqN,
    output logic        OUT_commitValid,
    output logic [5:0]  OUT_commitTagDst,
    output logic [4:0]  OUT_commitNmDst,
    output logic [31:0] OUT_commitResult
);
    localparam int IDX_W = $clog2(SIZE);
    typedef logic [IDX_W-1:0] idx_t;

    logic [5:0]      head;
    logic [5:0]      tail;
    logic [5:0]      count;
    idx_t            head_idx;
    idx_t            tail_idx;
    logic [SIZE-1:0] ent_valid;
    logic [SIZE-1:0] ent_done;
    logic [5:0]      ent_tag    [SIZE];
    logic [4:0]      ent_nm     [SIZE];
    logic [31:0]     ent_result [SIZE];

    logic                alloc_ok;
    logic                commit;
    logic [WB_COUNT-1:0] wb_hit;
    logic [SIZE-1:0]     flush_mask;
    idx_t                slot_off;

    // Age compare on the 6-bit sqN ring: true when a is younger than b.
    function automatic logic younger(input logic [5:0] a, input logic [5:0] b);
        return $signed(a - b) > 0;
    endfunction

    assign count        = tail - head;
    assign head_idx     = head[IDX_W-1:0];
    assign tail_idx     = tail[IDX_W-1:0];
    assign OUT_full     = (count == 6'(SIZE));
    assign OUT_allocSqN = tail;
    assign alloc_ok     = IN_allocValid && !OUT_full && !IN_invalidate;
    assign commit       = (count != 6'd0) && ent_done[head_idx] &&
                          !(IN_invalidate && younger(head, IN_invalidateSqN));

    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        wb_hit     = '0;
        flush_mask = '0;
        slot_off   = '0;
        for (int p = 0; p < WB_COUNT; p++) begin
            wb_hit[p] = IN_wbValid[p]
                     && ent_valid[IN_wbSqN[p][IDX_W-1:0]]
                     && ((IN_wbSqN[p] - head) < count)
                     && !(IN_invalidate && younger(IN_wbSqN[p], IN_invalidateSqN));
        end
        for (int i = 0; i < SIZE; i++) begin
            slot_off      = idx_t'(i) - head_idx;
            flush_mask[i] = IN_invalidate && younger(head + 6'(slot_off), IN_invalidateSqN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head             <= '0;
            tail             <= '0;
            ent_valid        <= '0;
            ent_done         <= '0;
            OUT_commitValid  <= 1'b0;
            OUT_commitTagDst <= '0;
            OUT_commitNmDst  <= '0;
            OUT_commitResult <= '0;
        end else begin
            // NOTE: non-blocking updates; when several target the same bit the last one in source order wins.
            OUT_commitValid <= commit;
            if (commit) begin
                head             <= head + 6'd1;
                OUT_commitTagDst <= ent_tag[head_idx];
                OUT_commitNmDst  <= ent_nm[head_idx];
                OUT_commitResult <= ent_result[head_idx];
            end
            if (IN_invalidate) begin
                tail <= IN_invalidateSqN + 6'd1;
            end else if (alloc_ok) begin
                tail <= tail + 6'd1;
            end
            for (int p = 0; p < WB_COUNT; p++) begin
                if (wb_hit[p]) begin
                    ent_done[IN_wbSqN[p][IDX_W-1:0]] <= 1'b1;
                end
            end
            if (alloc_ok) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
            end
            if (commit) begin
                ent_valid[head_idx] <= 1'b0;
                ent_done[head_idx]  <= 1'b0;
            end
            for (int i = 0; i < SIZE; i++) begin
                if (flush_mask[i]) begin
                    ent_valid[i] <= 1'b0;
                    ent_done[i]  <= 1'b0;
                end
            end
        end
    end

    // NOTE: payload storage has no reset; valid/done bits alone decide whether a slot holds data.
    always_ff @(posedge clk) begin
        if (alloc_ok) begin
            ent_tag[tail_idx] <= IN_allocTagDst;
            ent_nm[tail_idx]  <= IN_allocNmDst;
        end
        for (int p = 0; p < WB_COUNT; p++) begin
            if (wb_hit[p]) begin
                ent_result[IN_wbSqN[p][IDX_W-1:0]] <= IN_wbResult[p];
            end
        end
    end

endmodule
